bit_serial_comparator: RTL and testbench

//   Multi-bit magnitude comparator for the ALU compare path. It streams two WIDTH-bit operands MSB-first

---
 rtl/cmp_defs_pkg.sv | 12 +
 rtl/comparator_1bit.sv | 11 +
 rtl/bit_serial_comparator.sv | 138 +++++++++++++
 tb/tb_bit_serial_comparator.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_defs_pkg.sv
// cmp_defs: shared FSM state encodings and default width for the serial comparator.
package cmp_defs;

    typedef enum logic [1:0] {
        CMP_IDLE = 2'd0,
        CMP_RUN  = 2'd1,
        CMP_DONE = 2'd2
    } cmp_state_t;

    localparam int CMP_WIDTH_DEF = 8;

endpackage

// File: rtl/comparator_1bit.sv
// comparator_1bit: single-bit "x strictly greater than y" cell.
// Instantiated twice per operand pair, with the inputs swapped, to get a gt/lt pair.
module comparator_1bit (
    input  logic x,
    input  logic y,
    output logic g
);

    assign g = x & ~y;

endmodule

// File: rtl/bit_serial_comparator.sv
// bit_serial_comparator: unsigned magnitude comparator that walks both operands
// MSB-first, one bit per clock, and reports gt/eq/lt with a one-cycle done pulse.
// Optional macro CMP_EARLY_EXIT_EN: finish in the cycle the first differing bit
// is registered instead of always scanning all WIDTH bits.
module bit_serial_comparator
    import cmp_defs::*;
#(
    parameter int WIDTH = CMP_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] IDX_TOP = IW'(WIDTH - 1);

    cmp_state_t      state;
    cmp_state_t      state_nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IW-1:0]   idx;
    logic            gt_r;
    logic            lt_r;
    logic            bit_gt;
    logic            bit_lt;
    logic            decided;
    logic            gt_nxt;
    logic            lt_nxt;
    logic            accept;
    logic            last_bit;

    comparator_1bit u_cmp_ab (
        .x (a_q[idx]),
        .y (b_q[idx]),
        .g (bit_gt)
    );

    comparator_1bit u_cmp_ba (
        .x (b_q[idx]),
        .y (a_q[idx]),
        .g (bit_lt)
    );

    // The first differing bit from the top decides; later bits cannot override it.
    assign decided = gt_r | lt_r;
    assign gt_nxt  = gt_r | (~decided & bit_gt);
    assign lt_nxt  = lt_r | (~decided & bit_lt);

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CMP_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode, start acceptance and the final-bit condition.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        accept    = 1'b0;
        last_bit  = 1'b0;
        case (state)
            CMP_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = CMP_RUN;
                end
            end
            CMP_RUN: begin
                busy = 1'b1;
`ifdef CMP_EARLY_EXIT_EN
                last_bit = (idx == '0) || bit_gt || bit_lt;
`else
                last_bit = (idx == '0);
`endif
                if (last_bit) begin
                    state_nxt = CMP_DONE;
                end
            end
            CMP_DONE: begin
                state_nxt = CMP_IDLE;
            end
            default: begin
                state_nxt = CMP_IDLE;
            end
        endcase
    end

    // Operand capture, bit scan and result registers; results persist through IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q  <= '0;
            b_q  <= '0;
            idx  <= '0;
            gt_r <= 1'b0;
            lt_r <= 1'b0;
            done <= 1'b0;
            gt   <= 1'b0;
            eq   <= 1'b0;
            lt   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                a_q  <= a;
                b_q  <= b;
                idx  <= IDX_TOP;
                gt_r <= 1'b0;
                lt_r <= 1'b0;
                gt   <= 1'b0;
                eq   <= 1'b0;
                lt   <= 1'b0;
            end else if (state == CMP_RUN) begin
                gt_r <= gt_nxt;
                lt_r <= lt_nxt;
                if (idx != '0) begin
                    idx <= idx - IW'(1);
                end
                if (last_bit) begin
                    done <= 1'b1;
                    gt   <= gt_nxt;
                    lt   <= lt_nxt;
                    eq   <= ~gt_nxt & ~lt_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_bit_serial_comparator.sv
// tb_bit_serial_comparator: vector table, hand-written corner sequences and
// randomized operands checked against an arithmetic reference model.
module tb_bit_serial_comparator;

    localparam int W = 8;
`ifdef CMP_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic         gt;
    logic         eq;
    logic         lt;

    int checkCount = 0;
    int passCount  = 0;

    bit_serial_comparator #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .gt    (gt),
        .eq    (eq),
        .lt    (lt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         expGt;
        logic         expEq;
        logic         expLt;
        int           expLat;
    } vec_t;

    // Compare one observed value against its expected value and keep score.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Reference latency: full width, or up to the most significant differing bit when exiting early.
    function automatic int modelLatency(input logic [W-1:0] av, input logic [W-1:0] bv);
        int diff;
        diff = int'(av ^ bv);
        if (EARLY && diff != 0) begin
            return W - ($clog2(diff + 1) - 1);
        end
        return W;
    endfunction

    // Start one operation from IDLE, scramble the operands afterwards, and wait for done.
    task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 output int lat, output logic [2:0] flags, output logic cleared);
        @(negedge clk);
        start = 1'b1;
        a = av;
        b = bv;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        cleared = busy && !done && !gt && !eq && !lt;
        lat = 0;
        while (!done && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        flags = {gt, eq, lt};
    endtask

    // Run one operation and compare result, latency and the post-done hold against expectations.
    task automatic runCase(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic [2:0] expFlags, input int expLat);
        int lat;
        logic [2:0] flags;
        logic cleared;
        applyStimulus(av, bv, lat, flags, cleared);
        checkOutput({tag, " cleared after accept"}, 32'(cleared), 32'd1);
        checkOutput({tag, " gt/eq/lt"}, 32'(flags), 32'(expFlags));
        checkOutput({tag, " latency"}, 32'(lat), 32'(expLat));
        @(negedge clk);
        checkOutput({tag, " held in idle"}, {27'd0, busy, done, gt, eq, lt}, {29'd0, expFlags});
    endtask

    vec_t vecs[10];

    initial begin
        int lat;
        logic [2:0] flags;
        logic cleared;
        logic busyOk;
        int doneCount;
        int doneCycle;
        logic sawDone;

        vecs[0] = '{8'h5A, 8'h5A, 1'b0, 1'b1, 1'b0, 8};
        vecs[1] = '{8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, EARLY ? 1 : 8};
        vecs[2] = '{8'h00, 8'h01, 1'b0, 1'b0, 1'b1, 8};
        vecs[3] = '{8'hFF, 8'hFE, 1'b1, 1'b0, 1'b0, 8};
        vecs[4] = '{8'h01, 8'h80, 1'b0, 1'b0, 1'b1, EARLY ? 1 : 8};
        vecs[5] = '{8'h7F, 8'hFF, 1'b0, 1'b0, 1'b1, EARLY ? 1 : 8};
        vecs[6] = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 8};
        vecs[7] = '{8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, 8};
        vecs[8] = '{8'hC3, 8'hC1, 1'b1, 1'b0, 1'b0, EARLY ? 7 : 8};
        vecs[9] = '{8'h40, 8'h60, 1'b0, 1'b0, 1'b1, EARLY ? 3 : 8};

        rst_n = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset outputs", {27'd0, busy, done, gt, eq, lt}, 32'd0);
        rst_n = 1'b1;

        $display("[TB] vector table");
        for (int i = 0; i < 10; i++) begin
            runCase($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb,
                    {vecs[i].expGt, vecs[i].expEq, vecs[i].expLt}, vecs[i].expLat);
        end

        $display("[TB] start ignored while running");
        @(negedge clk);
        start = 1'b1;
        a = 8'h10;
        b = 8'h20;
        @(negedge clk);
        start = 1'b0;
        busyOk = 1'b1;
        doneCount = 0;
        doneCycle = -1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (cyc < modelLatency(8'h10, 8'h20) && !busy) busyOk = 1'b0;
            if (cyc > modelLatency(8'h10, 8'h20) && busy) busyOk = 1'b0;
            if (done) begin
                doneCount++;
                doneCycle = cyc;
                checkOutput("ignored start result", {29'd0, gt, eq, lt}, 32'b001);
            end
            if (cyc == 2) begin
                start = 1'b1;
                a = 8'hFF;
                b = 8'h00;
            end else if (cyc == 3) begin
                start = 1'b0;
            end
        end
        checkOutput("ignored start busy window", 32'(busyOk), 32'd1);
        checkOutput("ignored start done count", 32'(doneCount), 32'd1);
        checkOutput("ignored start done cycle", 32'(doneCycle), 32'(modelLatency(8'h10, 8'h20)));

        $display("[TB] reset mid-run");
        @(negedge clk);
        start = 1'b1;
        a = 8'h00;
        b = 8'h01;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort outputs", {27'd0, busy, done, gt, eq, lt}, 32'd0);
        sawDone = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done || busy) sawDone = 1'b1;
        end
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) sawDone = 1'b1;
        end
        checkOutput("no done after abort", 32'(sawDone), 32'd0);
        runCase("after reset", 8'h33, 8'h33, 3'b010, 8);

        $display("[TB] back-to-back");
        applyStimulus(8'h00, 8'h05, lat, flags, cleared);
        checkOutput("b2b first result", 32'(flags), 32'b001);
        @(negedge clk);
        checkOutput("b2b held before start", {27'd0, busy, done, gt, eq, lt}, 32'b00001);
        start = 1'b1;
        a = 8'h01;
        b = 8'h00;
        @(negedge clk);
        start = 1'b0;
        checkOutput("b2b accepted", {27'd0, busy, done, gt, eq, lt}, 32'b10000);
        lat = 0;
        while (!done && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("b2b second result", {29'd0, gt, eq, lt}, 32'b100);
        checkOutput("b2b second latency", 32'(lat), 32'(modelLatency(8'h01, 8'h00)));

        $display("[TB] randomized operands");
        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
            runCase($sformatf("rand%0d", n), ra, rb,
                    {ra > rb, ra == rb, ra < rb}, modelLatency(ra, rb));
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    // Hard stop if the run ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
